// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard request / pipeline control bundle between hazard unit and pipe.
// master drives the requests, slave (the controller) drives the controls.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             stall2;
  logic             redirect;
  logic             halt_req;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output stall,
    output stall2,
    output redirect,
    output halt_req,
    input  pc_we,
    input  ifid_we,
    input  ifid_flush,
    input  idex_bubble,
    input  halted,
    input  stall_cycles,
    input  flush_count
  );

  modport slave (
    input  stall,
    input  stall2,
    input  redirect,
    input  halt_req,
    output pc_we,
    output ifid_we,
    output ifid_flush,
    output idex_bubble,
    output halted,
    output stall_cycles,
    output flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// PC / IF-ID / ID-EX control from hazard-unit stall and redirect requests.
// Define PIPE_PERF_CNT_EN to build the saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD2 = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic do_s2;
  logic do_s1;
  logic do_halt;
  logic do_redir;

  logic pc_we;
  logic ifid_we;
  logic flush;
  logic bubble;
  logic halted;

  // Mutually exclusive request lines in RUN priority order
  always_comb begin
    do_s2    = hz.stall2;
    do_s1    = hz.stall & ~hz.stall2;
    do_halt  = hz.halt_req & ~hz.stall
             & ~hz.stall2;
    do_redir = hz.redirect & ~hz.stall
             & ~hz.stall2 & ~hz.halt_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_we    = 1'b0;
    ifid_we  = 1'b0;
    flush    = 1'b0;
    bubble   = 1'b0;
    halted   = 1'b0;
    case (state)
      RUN: begin
        unique case (1'b1)
          do_s2: begin
            bubble   = 1'b1;
            state_nx = HOLD2;
          end
          do_s1: begin
            bubble = 1'b1;
          end
          do_halt: begin
            state_nx = HALT;
          end
          do_redir: begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            flush   = 1'b1;
          end
          default: begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        endcase
      end
      HOLD2: begin
        bubble   = 1'b1;
        state_nx = RUN;
      end
      HALT: begin
        bubble = 1'b1;
        halted = 1'b1;
      end
      default: begin
        state_nx = RUN;
      end
    endcase
    // Reset freezes the front end and feeds nops into EX
    if (!rst_n) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      flush    = 1'b0;
      bubble   = 1'b1;
      halted   = 1'b0;
      state_nx = RUN;
    end
  end

  assign hz.pc_we       = pc_we;
  assign hz.ifid_we     = ifid_we;
  assign hz.ifid_flush  = flush;
  assign hz.idex_bubble = bubble;
  assign hz.halted      = halted;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             cnt_stall;

  assign cnt_stall = bubble & (state != HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (cnt_stall && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_count  = '0;
`endif

  a_flush_bubble_excl : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(hz.ifid_flush && hz.idex_bubble)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a bubble-count model.
// Directed literal checks pin the model; counters built with CNT_W=4.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic stall2 = 1'b0;
  logic redirect = 1'b0;
  logic halt_req = 1'b0;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b1;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  assign bus.stall    = stall;
  assign bus.stall2   = stall2;
  assign bus.redirect = redirect;
  assign bus.halt_req = halt_req;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
  );

  always #5 clk = ~clk;

  // Model: bubbles still owed, sticky halt, plain event counts
  int owed = 0;
  bit mhalt = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  // {pc_we, ifid_we, ifid_flush, idex_bubble, halted}
  function automatic logic [4:0] model_out();
    if (!rst_n) return 5'b00010;
    if (mhalt) return 5'b00011;
    if (owed > 0 || stall || stall2) return 5'b00010;
    if (halt_req) return 5'b00000;
    if (redirect) return 5'b11100;
    return 5'b11000;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [4:0] e;
    if (!rst_n) begin
      owed    = 0;
      mhalt   = 1'b0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      e = model_out();
      if (e[1] && !mhalt && m_stall < MAXC) m_stall++;
      if (e[2] && m_flush < MAXC) m_flush++;
      if (mhalt) begin
      end else if (owed > 0) begin
        owed--;
      end else if (stall2) begin
        owed = 1;
      end else if (!stall && halt_req) begin
        mhalt = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (cmp_en) begin
      e = model_out();
      chk("pc_we", 32'(bus.pc_we), 32'(e[4]));
      chk("ifid_we", 32'(bus.ifid_we), 32'(e[3]));
      chk("ifid_flush", 32'(bus.ifid_flush), 32'(e[2]));
      chk("idex_bubble", 32'(bus.idex_bubble), 32'(e[1]));
      chk("halted", 32'(bus.halted), 32'(e[0]));
      chk("stall_cycles", 32'(bus.stall_cycles),
          PERF ? m_stall : 0);
      chk("flush_count", 32'(bus.flush_count),
          PERF ? m_flush : 0);
    end
  end

  task automatic cyc(input logic s, input logic s2,
                     input logic rd, input logic hr);
    @(posedge clk);
    #1;
    stall    = s;
    stall2   = s2;
    redirect = rd;
    halt_req = hr;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc_we", 32'(bus.pc_we), 0);
    chk("rst_bubble", 32'(bus.idex_bubble), 1);
    chk("rst_halted", 32'(bus.halted), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_pc_we", 32'(bus.pc_we), 1);

    repeat (3) cyc(0, 0, 0, 0);
    chk("idle_pc_we", 32'(bus.pc_we), 1);
    chk("idle_bubble", 32'(bus.idex_bubble), 0);
    chk("idle_cnt", 32'(bus.stall_cycles), 0);

    cyc(1, 0, 0, 0);
    chk("s1_pc_we", 32'(bus.pc_we), 0);
    chk("s1_bubble", 32'(bus.idex_bubble), 1);
    cyc(0, 0, 0, 0);
    chk("s1_after_pc", 32'(bus.pc_we), 1);
    chk("s1_cnt", 32'(bus.stall_cycles), PERF ? 1 : 0);

    cyc(1, 1, 0, 0);
    chk("s2_bub0", 32'(bus.idex_bubble), 1);
    cyc(0, 0, 1, 0);
    chk("s2_bub1", 32'(bus.idex_bubble), 1);
    chk("s2_noflush", 32'(bus.ifid_flush), 0);
    chk("s2_pc_we", 32'(bus.pc_we), 0);
    cyc(0, 0, 0, 0);
    chk("s2_after_pc", 32'(bus.pc_we), 1);
    chk("s2_cnt", 32'(bus.stall_cycles), PERF ? 3 : 0);

    cyc(0, 0, 1, 0);
    chk("rd_flush", 32'(bus.ifid_flush), 1);
    chk("rd_pc_we", 32'(bus.pc_we), 1);
    cyc(0, 0, 0, 0);
    chk("rd_cnt", 32'(bus.flush_count), PERF ? 1 : 0);

    cyc(0, 0, 0, 1);
    chk("hr_pc_we", 32'(bus.pc_we), 0);
    chk("hr_bubble", 32'(bus.idex_bubble), 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, (i % 2) == 0, 0);
      chk("halt_hold", 32'(bus.halted), 1);
    end
    chk("halt_pc_we", 32'(bus.pc_we), 0);
    chk("halt_cnt", 32'(bus.stall_cycles), PERF ? 3 : 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_halted", 32'(bus.halted), 0);
    chk("arst_cnt", 32'(bus.stall_cycles), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("resume_pc_we", 32'(bus.pc_we), 1);

    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("sat_cnt", 32'(bus.stall_cycles), PERF ? 15 : 0);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      rst_n    = ($urandom_range(0, 99) >= 4);
      stall    = ($urandom_range(0, 3) == 0);
      stall2   = stall && ($urandom_range(0, 2) == 0);
      redirect = ($urandom_range(0, 2) == 0);
      halt_req = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
